// File: rtl/lookup_engine_v2_if.sv
// Signal bundle for lookup_engine_v2: lookup request, lookup result and the
// match/action table write channels.
interface lookup_engine_v2_if #(
    parameter int unsigned PHV_LEN = 48*8+32*8+16*8+5*20+256,
    parameter int unsigned KEY_LEN = 197,
    parameter int unsigned ACT_LEN = 625,
    parameter int unsigned ADDR_W  = 4
);
    logic [KEY_LEN-1:0] extract_key;
    logic               key_valid;
    logic [PHV_LEN-1:0] phv_in;

    logic [ACT_LEN-1:0] action;
    logic               action_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic               lookup_hit;

    logic [KEY_LEN-1:0] lookup_din;
    logic [KEY_LEN-1:0] lookup_din_mask;
    logic [ADDR_W-1:0]  lookup_din_addr;
    logic               lookup_din_vld;
    logic               lookup_din_en;

    logic [ACT_LEN-1:0] action_data_in;
    logic [ADDR_W-1:0]  action_addr;
    logic               action_en;

    modport master (
        output extract_key, key_valid, phv_in,
        output lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_vld, lookup_din_en,
        output action_data_in, action_addr, action_en,
        input  action, action_valid, phv_out, lookup_hit
    );

    modport slave (
        input  extract_key, key_valid, phv_in,
        input  lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_vld, lookup_din_en,
        input  action_data_in, action_addr, action_en,
        output action, action_valid, phv_out, lookup_hit
    );
endinterface

// File: rtl/lookup_engine_v2.sv
// Pipelined ternary match-action lookup (key sampled at edge N, result at edge N+3).
// Define LKUP_HIT_CNT_EN to add saturating per-entry hit counters and a miss counter.
module lookup_engine_v2 #(
    parameter int unsigned        STAGE       = 0,
    parameter int unsigned        PHV_LEN     = 48*8+32*8+16*8+5*20+256,
    parameter int unsigned        KEY_LEN     = 197,
    parameter int unsigned        ACT_LEN     = 625,
    parameter int unsigned        DEPTH       = 16,
    parameter int unsigned        ADDR_W      = 4,
    parameter logic [ACT_LEN-1:0] DEFAULT_ACT = ACT_LEN'('h3f)
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef LKUP_HIT_CNT_EN
    input  logic [ADDR_W-1:0] cnt_rd_addr,
    output logic [31:0]       cnt_rd_data,
    output logic [31:0]       miss_cnt,
`endif
    lookup_engine_v2_if.slave bus
);
    logic [KEY_LEN-1:0] key_mem_q  [DEPTH];
    logic [KEY_LEN-1:0] mask_mem_q [DEPTH];
    logic [ACT_LEN-1:0] act_mem_q  [DEPTH];
    logic [DEPTH-1:0]   vld_mem_q;
    logic               ent_wr;
    logic               act_wr;

    assign ent_wr = bus.lookup_din_en && (32'(bus.lookup_din_addr) < DEPTH);
    assign act_wr = bus.action_en && (32'(bus.action_addr) < DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_mem_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                key_mem_q[i]  <= '0;
                mask_mem_q[i] <= '0;
                act_mem_q[i]  <= '0;
            end
        end else begin
            if (ent_wr) begin
                key_mem_q[bus.lookup_din_addr]  <= bus.lookup_din;
                mask_mem_q[bus.lookup_din_addr] <= bus.lookup_din_mask;
                vld_mem_q[bus.lookup_din_addr]  <= bus.lookup_din_vld;
            end
            if (act_wr) begin
                act_mem_q[bus.action_addr] <= bus.action_data_in;
            end
        end
    end

    logic               vld_s1_q, vld_s2_q, vld_s3_q, action_valid_q;
    logic [KEY_LEN-1:0] key_s1_q;
    logic [PHV_LEN-1:0] phv_s1_q, phv_s2_q, phv_s3_q, phv_out_q;
    logic               hit_s2_q, hit_s3_q, lookup_hit_q;
    logic [ADDR_W-1:0]  idx_s2_q;
    logic [ACT_LEN-1:0] act_s3_q, action_q;
    logic               hit_d;
    logic [ADDR_W-1:0]  idx_d;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (vld_mem_q[i] && (((key_s1_q ^ key_mem_q[i]) & ~mask_mem_q[i]) == '0)) begin
                hit_d = 1'b1;
                idx_d = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1_q       <= 1'b0;
            key_s1_q       <= '0;
            phv_s1_q       <= '0;
            vld_s2_q       <= 1'b0;
            hit_s2_q       <= 1'b0;
            idx_s2_q       <= '0;
            phv_s2_q       <= '0;
            vld_s3_q       <= 1'b0;
            hit_s3_q       <= 1'b0;
            act_s3_q       <= '0;
            phv_s3_q       <= '0;
            action_valid_q <= 1'b0;
            lookup_hit_q   <= 1'b0;
            action_q       <= '0;
            phv_out_q      <= '0;
        end else begin
            vld_s1_q       <= bus.key_valid;
            vld_s2_q       <= vld_s1_q;
            vld_s3_q       <= vld_s2_q;
            action_valid_q <= vld_s3_q;
            if (bus.key_valid) begin
                key_s1_q <= bus.extract_key;
                phv_s1_q <= bus.phv_in;
            end
            if (vld_s1_q) begin
                hit_s2_q <= hit_d;
                idx_s2_q <= idx_d;
                phv_s2_q <= phv_s1_q;
            end
            if (vld_s2_q) begin
                hit_s3_q <= hit_s2_q;
                act_s3_q <= hit_s2_q ? act_mem_q[idx_s2_q] : DEFAULT_ACT;
                phv_s3_q <= phv_s2_q;
            end
            if (vld_s3_q) begin
                lookup_hit_q <= hit_s3_q;
                action_q     <= act_s3_q;
                phv_out_q    <= phv_s3_q;
            end
        end
    end

    assign bus.action_valid = action_valid_q;
    assign bus.action       = action_q;
    assign bus.phv_out      = phv_out_q;
    assign bus.lookup_hit   = lookup_hit_q;

`ifdef LKUP_HIT_CNT_EN
    logic [31:0] hit_cnt_q [DEPTH];
    logic [31:0] miss_cnt_q;
    logic [31:0] cnt_rd_q;

    // Counters advance when the S3 action read happens; an entry rewrite wins over a bump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hit_cnt_q[i] <= '0;
            end
            miss_cnt_q <= '0;
            cnt_rd_q   <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_wr && (bus.lookup_din_addr == ADDR_W'(i))) begin
                    hit_cnt_q[i] <= '0;
                end else if (vld_s2_q && hit_s2_q && (idx_s2_q == ADDR_W'(i)) &&
                             (hit_cnt_q[i] != '1)) begin
                    hit_cnt_q[i] <= hit_cnt_q[i] + 32'd1;
                end
            end
            if (vld_s2_q && !hit_s2_q && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            cnt_rd_q <= (32'(cnt_rd_addr) < DEPTH) ? hit_cnt_q[cnt_rd_addr] : '0;
        end
    end

    assign cnt_rd_data = cnt_rd_q;
    assign miss_cnt    = miss_cnt_q;
`endif
endmodule

// File: tb/tb_lookup_engine_v2.sv
// Self-checking bench for lookup_engine_v2: directed scenarios plus randomized traffic
// checked every cycle against an event-queue reference model of the lookup pipeline.
module tb_lookup_engine_v2;
    localparam int unsigned PHV_LEN = 48*8+32*8+16*8+5*20+256;
    localparam int unsigned KEY_LEN = 197;
    localparam int unsigned ACT_LEN = 625;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned W       = PHV_LEN;
    localparam logic [ACT_LEN-1:0] DEF_ACT = ACT_LEN'('h3f);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lookup_engine_v2_if #(
        .PHV_LEN (PHV_LEN),
        .KEY_LEN (KEY_LEN),
        .ACT_LEN (ACT_LEN),
        .ADDR_W  (ADDR_W)
    ) bus ();

`ifdef LKUP_HIT_CNT_EN
    logic [ADDR_W-1:0] cnt_rd_addr = '0;
    logic [31:0]       cnt_rd_data;
    logic [31:0]       miss_cnt;
`endif

    lookup_engine_v2 #(
        .STAGE       (0),
        .PHV_LEN     (PHV_LEN),
        .KEY_LEN     (KEY_LEN),
        .ACT_LEN     (ACT_LEN),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .DEFAULT_ACT (DEF_ACT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef LKUP_HIT_CNT_EN
        .cnt_rd_addr (cnt_rd_addr),
        .cnt_rd_data (cnt_rd_data),
        .miss_cnt    (miss_cnt),
`endif
        .bus         (bus)
    );

    // Reference model: shadow tables plus a queue of lookups tagged with their age in edges.
    typedef struct {
        int                 age;
        logic [KEY_LEN-1:0] key;
        logic [PHV_LEN-1:0] phv;
        bit                 hit;
        int                 idx;
        logic [ACT_LEN-1:0] act;
    } lk_t;

    logic [KEY_LEN-1:0] m_key  [DEPTH];
    logic [KEY_LEN-1:0] m_mask [DEPTH];
    bit                 m_vld  [DEPTH];
    logic [ACT_LEN-1:0] m_act  [DEPTH];
    lk_t                pend [$];
    bit                 e_valid, e_hit;
    logic [ACT_LEN-1:0] e_act;
    logic [PHV_LEN-1:0] e_phv;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        logic [W-1:0] g;
        logic [W-1:0] e;
        int           c;
        n_tests++;
        if (got !== exp) begin
            g = got;
            e = exp;
            c = 0;
            while ((g[63:0] === e[63:0]) && (c < 17)) begin
                g = g >> 64;
                e = e >> 64;
                c++;
            end
            n_fail++;
            $display("FAIL %s: word %0d got=%h expected=%h", tag, c, g[63:0], e[63:0]);
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v = '0;
        for (int i = 0; i < 36; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    function automatic void ref_lookup(input logic [KEY_LEN-1:0] k, output bit hit,
                                       output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!hit && m_vld[i] && ((k | m_mask[i]) == (m_key[i] | m_mask[i]))) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    // Advance the model across the coming clock edge using the inputs now on the bus.
    task automatic model_edge();
        lk_t nq [$];
        lk_t n;
        e_valid = 1'b0;
        foreach (pend[j]) begin
            lk_t p;
            p = pend[j];
            p.age++;
            if (p.age == 1) ref_lookup(p.key, p.hit, p.idx);
            else if (p.age == 2) p.act = p.hit ? m_act[p.idx] : DEF_ACT;
            if (p.age == 3) begin
                e_valid = 1'b1;
                e_hit   = p.hit;
                e_act   = p.act;
                e_phv   = p.phv;
            end else begin
                nq.push_back(p);
            end
        end
        if (bus.lookup_din_en && (32'(bus.lookup_din_addr) < DEPTH)) begin
            m_key[bus.lookup_din_addr]  = bus.lookup_din;
            m_mask[bus.lookup_din_addr] = bus.lookup_din_mask;
            m_vld[bus.lookup_din_addr]  = bus.lookup_din_vld;
        end
        if (bus.action_en && (32'(bus.action_addr) < DEPTH)) begin
            m_act[bus.action_addr] = bus.action_data_in;
        end
        if (bus.key_valid) begin
            n.age = 0;
            n.key = bus.extract_key;
            n.phv = bus.phv_in;
            n.hit = 1'b0;
            n.idx = 0;
            n.act = '0;
            nq.push_back(n);
        end
        pend = nq;
    endtask

    task automatic idle();
        bus.key_valid     = 1'b0;
        bus.lookup_din_en = 1'b0;
        bus.action_en     = 1'b0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("valid", W'(bus.action_valid), W'(e_valid));
        check("hit", W'(bus.lookup_hit), W'(e_hit));
        check("action", W'(bus.action), W'(e_act));
        check("phv", W'(bus.phv_out), W'(e_phv));
        idle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_key(input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p);
        bus.extract_key = k;
        bus.phv_in      = p;
        bus.key_valid   = 1'b1;
    endtask

    task automatic wr_entry(input int a, input logic [KEY_LEN-1:0] k,
                            input logic [KEY_LEN-1:0] m, input bit v);
        bus.lookup_din_addr = ADDR_W'(a);
        bus.lookup_din      = k;
        bus.lookup_din_mask = m;
        bus.lookup_din_vld  = v;
        bus.lookup_din_en   = 1'b1;
    endtask

    task automatic wr_act(input int a, input logic [ACT_LEN-1:0] d);
        bus.action_addr    = ADDR_W'(a);
        bus.action_data_in = d;
        bus.action_en      = 1'b1;
    endtask

    task automatic reset_dut();
        #2;
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_key[i]  = '0;
            m_mask[i] = '0;
            m_vld[i]  = 1'b0;
            m_act[i]  = '0;
        end
        pend.delete();
        e_valid = 1'b0;
        e_hit   = 1'b0;
        e_act   = '0;
        e_phv   = '0;
        @(posedge clk);
        #1;
        check("rst_valid", W'(bus.action_valid), W'(0));
        check("rst_hit", W'(bus.lookup_hit), W'(0));
        check("rst_action", W'(bus.action), W'(0));
        check("rst_phv", W'(bus.phv_out), W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KEY_LEN-1:0] t4k [5];
        logic [KEY_LEN-1:0] pool [4];
        logic [KEY_LEN-1:0] k;
        logic [KEY_LEN-1:0] msk;
        logic [7:0]         vpat;
        bit                 seen;
        int                 b;
        int                 r;

        bus.extract_key     = '0;
        bus.phv_in          = '0;
        bus.lookup_din      = '0;
        bus.lookup_din_mask = '0;
        bus.lookup_din_addr = '0;
        bus.lookup_din_vld  = 1'b0;
        bus.action_data_in  = '0;
        bus.action_addr     = '0;
        idle();
        @(posedge clk);
        #1;
        reset_dut();
`ifdef LKUP_HIT_CNT_EN
        check("rst_miss_cnt", W'(miss_cnt), W'(0));
`endif

        // Empty table: default action
        set_key('h1, 'hAB);
        run(4);
        check("t1_valid", W'(bus.action_valid), W'(1));
        check("t1_act", W'(bus.action), W'('h3f));
        check("t1_hit", W'(bus.lookup_hit), W'(0));
        check("t1_phv", W'(bus.phv_out), W'('hAB));

        // Exact-match entry
        wr_entry(2, 'h55, '0, 1'b1);
        wr_act(2, 'hDEAD);
        step();
        set_key('h55, 'h155);
        run(4);
        check("t2_act", W'(bus.action), W'('hDEAD));
        check("t2_hit", W'(bus.lookup_hit), W'(1));
        set_key('h54, 'h154);
        run(4);
        check("t2m_act", W'(bus.action), W'('h3f));
        check("t2m_hit", W'(bus.lookup_hit), W'(0));

        // Wildcard at 1, exact at 0: lowest index wins
        wr_entry(1, '0, '1, 1'b1);
        wr_act(1, 'h11);
        step();
        wr_entry(0, 'h7, '0, 1'b1);
        wr_act(0, 'h22);
        step();
        set_key('h7, 'h300);
        run(4);
        check("t3_act7", W'(bus.action), W'('h22));
        set_key('h8, 'h301);
        run(4);
        check("t3_act8", W'(bus.action), W'('h11));
        check("t3_hit8", W'(bus.lookup_hit), W'(1));

        // Back-to-back alternating hit/miss
        wr_entry(1, '0, '0, 1'b0);
        step();
        t4k = '{'h7, 'h54, 'h55, 'h54, 'h7};
        vpat = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) set_key(t4k[i], PHV_LEN'(32'h400 + i));
            step();
            vpat[i] = bus.action_valid;
        end
        check("t4_pattern", W'(vpat), W'(8'b1111_1000));
        check("t4_last_phv", W'(bus.phv_out), W'('h404));
        check("t4_last_act", W'(bus.action), W'('h22));

        // Delete on the edge the key enters S1: miss
        set_key('h55, 'h500);
        wr_entry(2, 'h55, '0, 1'b0);
        run(4);
        check("t5a_hit", W'(bus.lookup_hit), W'(0));
        check("t5a_act", W'(bus.action), W'('h3f));
        // Delete on the edge the key enters S2: compare already done, still hits
        wr_entry(2, 'h55, '0, 1'b1);
        step();
        set_key('h55, 'h501);
        step();
        wr_entry(2, 'h55, '0, 1'b0);
        run(3);
        check("t5b_hit", W'(bus.lookup_hit), W'(1));
        check("t5b_act", W'(bus.action), W'('hDEAD));
        check("t5b_phv", W'(bus.phv_out), W'('h501));

        // Reset with two lookups in flight
        wr_entry(2, 'h55, '0, 1'b1);
        step();
        set_key('h55, 'h600);
        step();
        set_key('h55, 'h601);
        step();
        reset_dut();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | bus.action_valid;
        end
        check("t6_no_valid", W'(seen), W'(0));
        set_key('h55, 'h602);
        run(4);
        check("t6_hit", W'(bus.lookup_hit), W'(0));
        check("t6_act", W'(bus.action), W'('h3f));

`ifdef LKUP_HIT_CNT_EN
        check("cnt_miss", W'(miss_cnt), W'(1));
        wr_entry(2, 'h55, '0, 1'b1);
        wr_act(2, 'hBEEF);
        step();
        for (int i = 0; i < 3; i++) begin
            set_key('h55, PHV_LEN'(32'h700 + i));
            step();
        end
        run(3);
        cnt_rd_addr = 2;
        step();
        check("cnt_hit2", W'(cnt_rd_data), W'(3));
        check("cnt_miss_hold", W'(miss_cnt), W'(1));
        wr_entry(2, 'h55, '0, 1'b1);
        step();
        step();
        check("cnt_clear2", W'(cnt_rd_data), W'(0));
`endif

        // Randomized traffic against the model
        reset_dut();
        for (int i = 0; i < 4; i++) pool[i] = KEY_LEN'(rand_vec());
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(9) < 7) begin
                k = pool[$urandom_range(3)];
                if ($urandom_range(4) == 0) begin
                    b = $urandom_range(KEY_LEN - 1);
                    k[b] = ~k[b];
                end
                set_key(k, PHV_LEN'(rand_vec()));
            end
            if ($urandom_range(9) < 2) begin
                r = $urandom_range(9);
                msk = (r < 5) ? '0 : (r == 5) ? '1 : KEY_LEN'(rand_vec());
                wr_entry($urandom_range(DEPTH - 1), pool[$urandom_range(3)], msk,
                         $urandom_range(4) != 0);
            end
            if ($urandom_range(9) < 2) wr_act($urandom_range(DEPTH - 1), ACT_LEN'(rand_vec()));
            step();
        end
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lookup_engine_v2.md
Name: lookup_engine_v2

Overview:
Parametrised successor of the per-stage match-action lookup. It holds a DEPTH-entry ternary match table and a DEPTH-entry action table in registers, both written through the control channel. Each cycle it can accept one extracted key plus its PHV. After a fixed latency it emits the winning action (or the default action on a miss), the PHV and a hit flag to the action engine. It sits between the key extractor and the action engine in each pipeline stage.

Parameters:
STAGE  0  stage index; informational only, no functional effect
PHV_LEN  48*8+32*8+16*8+5*20+256  PHV width
KEY_LEN  197  match key width
ACT_LEN  625  action word width
DEPTH  16  table entries, must be ≥2
ADDR_W  4  entry address width, must satisfy 2**ADDR_W ≥ DEPTH
DEFAULT_ACT  'h3f  action emitted on a miss, zero-extended to ACT_LEN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
extract_key  in  KEY_LEN  lookup key
key_valid  in  1  key/PHV valid strobe, one lookup per cycle
phv_in  in  PHV_LEN  PHV accompanying the key
action  out  ACT_LEN  resulting action
action_valid  out  1  one-cycle strobe qualifying action/phv_out/lookup_hit
phv_out  out  PHV_LEN  PHV delayed to match action
lookup_hit  out  1  1 = table hit, 0 = default action
lookup_din  in  KEY_LEN  entry key to write
lookup_din_mask  in  KEY_LEN  entry mask; bit=1 means don't care
lookup_din_addr  in  ADDR_W  entry index
lookup_din_vld  in  1  valid bit written with the entry (0 deletes the entry)
lookup_din_en  in  1  entry write strobe
action_data_in  in  ACT_LEN  action word to write
action_addr  in  ADDR_W  action index
action_en  in  1  action write strobe

Behaviour:
- Reset: action=0, action_valid=0, phv_out=0, lookup_hit=0. All entry valid bits cleared, all pipeline valid bits cleared. Key, mask and action storage reset to 0.
- Reset mid-operation: every in-flight lookup is dropped with no output. After rst_n deasserts the table is empty.
- Match rule: entry i hits when valid[i] is set and ((extract_key ^ key[i]) & ~mask[i]) == 0.
- Priority: if several entries hit, the lowest index wins.
- Pipeline is fully pipelined with fixed latency 3. A key sampled at edge N produces action_valid at edge N+3.
  - S1: register key, PHV and valid.
  - S2: parallel compare and priority encode; register hit and index.
  - S3: read the action table, or select DEFAULT_ACT on a miss.
  - Output registers update at the third edge.
- Back-to-back keys: one result per key, in order, no bubbles. action_valid follows the key_valid pattern delayed by 3.
- No backpressure. The downstream stage must always accept results.
- Control writes take effect at the next edge.
  - A lookup compares in S2 against the table as registered at that edge.
  - A lookup reads the action table in S3 as registered at that edge.
  - Same-cycle write and lookup: the lookup sees the old content.
  - Writes to an address ≥ DEPTH are ignored.
- Entry and action writes are independent and may occur in the same cycle.
- An all-ones mask on a valid entry is a wildcard that matches any key.
- Outputs hold their last values when action_valid=0.

Optional Feature:
LKUP_HIT_CNT_EN
- When defined, adds three ports: cnt_rd_addr (in, ADDR_W), cnt_rd_data (out, 32), miss_cnt (out, 32).
- Per entry, a 32-bit saturating counter increments in S3 when that entry wins.
- miss_cnt increments once per miss, also saturating.
- cnt_rd_data is a registered read with 1-cycle latency.
- An entry write to index i clears counter i at the same edge; the clear has priority over a same-cycle increment.
- All counters reset to 0.
- When undefined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- Empty table after reset; send key 'h1 with phv 'hAB -> 3 cycles later action_valid=1, action='h3f, lookup_hit=0, phv_out='hAB.
- Write entry 2 (key 'h55, mask 0, vld 1) and action 2 = 'hDEAD; send key 'h55 -> action='hDEAD, lookup_hit=1. Send key 'h54 -> action='h3f, lookup_hit=0.
- Entry 1 is a wildcard (mask all ones) with action 'h11; entry 0 has key 'h7 with action 'h22. Send key 'h7 -> 'h22; send key 'h8 -> 'h11.
- Five consecutive key_valid cycles alternating hit/miss -> five consecutive action_valid cycles, correct order and PHVs.
- In the same cycle as key 'h55 is sampled into S1, delete entry 2 (vld=0) -> that key misses. Same-cycle case with the key already in S2 -> that key still hits.
- Assert rst_n=0 with two lookups in flight -> no action_valid is produced and a subsequent key 'h55 misses. With LKUP_HIT_CNT_EN defined, 3 hits on entry 2 -> reading cnt_rd_addr=2 returns 3.
